// File: rtl/gate_truth_sequencer.sv
// Drives a 2-input gate through 00,01,10,11, samples y per vector and checks it against EXPECT_TT.
// Optional: define GATE_SEQ_HALT_ON_FAIL_EN to end the run at the first mismatching vector.
module gate_truth_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter logic [3:0]  EXPECT_TT     = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [3:0] captured
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    // Capture happens on the edge that would take the counter to SETTLE_CYCLES.
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

`ifdef GATE_SEQ_HALT_ON_FAIL_EN
    localparam logic HALT_ON_FAIL = 1'b1;
`else
    localparam logic HALT_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          mismatch;
    logic [3:0]    fail_next;
    logic [3:0]    cap_next;
    logic          end_run;

    always_comb begin
        mismatch       = y_in ^ EXPECT_TT[idx];
        fail_next      = fail_mask;
        fail_next[idx] = mismatch;
        cap_next       = captured;
        cap_next[idx]  = y_in;
        end_run        = (idx == 2'd3) || (HALT_ON_FAIL && mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 2'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'b0000;
            captured  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SETTLE;
                        cnt       <= '0;
                        idx       <= 2'd0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_mask <= 4'b0000;
                        captured  <= 4'b0000;
                    end
                end
                SETTLE: begin
                    if (cnt == LAST) begin
                        captured  <= cap_next;
                        fail_mask <= fail_next;
                        cnt       <= '0;
                        if (end_run) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                            pass  <= (fail_next == 4'b0000);
                        end else begin
                            idx            <= idx + 2'd1;
                            {a_out, b_out} <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_truth_sequencer.md
# gate_truth_sequencer

- Sequential stimulus/response stage wrapped around a 2-input combinational gate such as `and_gate`.
- Upstream side: drives the gate inputs `a`/`b` through all four combinations in order 00, 01, 10, 11, holding each for a programmable settle time.
- Downstream side: consumes the gate output `y`, captures one sample per vector and compares it against an expected truth table.
- Reports pass/fail per vector; used for in-fabric self-test of the gate library.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 10, clock cycles each vector is held before `y_in` is sampled; legal range 1..255.
- `EXPECT_TT`, default 4'b1000, expected `y` per vector index; bit k = expected output for `{a,b}` = k (default = AND).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a test run; sampled only in IDLE.
- `a_out`  out  1  drives gate input `a`.
- `b_out`  out  1  drives gate input `b`.
- `y_in`  in  1  gate output `y`, combinational from `a_out`/`b_out`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  run completed with no mismatch; held until next accepted start.
- `fail_mask`  out  4  bit k set if vector k mismatched; held until next accepted start.
- `captured`  out  4  bit k = sampled `y_in` for vector k; held until next accepted start.

## Operation

- FSM states:
  - IDLE: outputs quiescent; `start`=1 → SETTLE.
  - SETTLE: hold current vector, count settle cycles.
  - DONE: one cycle, pulses `done`, → IDLE.
- Vector index `idx` is 2 bits; `a_out` = `idx[1]`, `b_out` = `idx[0]`.
- Start accepted (IDLE, `start`=1) at edge E0:
  - `idx`=0, `a_out`/`b_out`=0/0, `busy`=1.
  - `pass`, `fail_mask`, `captured` cleared to 0.
  - Settle counter = 0.
- SETTLE: counter increments each edge; the counter has width to hold `SETTLE_CYCLES`, i.e. ceil(log2(SETTLE_CYCLES+1)) bits.
- Edge at which counter reaches `SETTLE_CYCLES`:
  - `captured[idx]` ← `y_in`.
  - `fail_mask[idx]` ← `y_in` ^ `EXPECT_TT[idx]`.
  - If `idx` < 3: `idx`++, next vector driven, counter = 0.
  - If `idx` == 3: → DONE.
- Entry to DONE at the same edge as the last capture:
  - `busy`=0, `done`=1, `a_out`=`b_out`=0.
  - `pass` = (final `fail_mask` == 0).
- `start` while `busy`=1: ignored, no queuing.
- `start` in the `done` cycle: the FSM is in DONE, not IDLE, so start is ignored. The earliest restart is the cycle after `done`.
- `idx` never wraps; the run ends after vector 3.

## Timing

- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `captured`=0, state IDLE.
- Vector k driven from edge E(k·S) to E((k+1)·S), with S = `SETTLE_CYCLES`; sampled at edge E((k+1)·S).
- `done` high for exactly the cycle following edge E(4·S); `busy` high from after E0 through edge E(4·S).
- Start-to-done latency: 4·S edges.
- S=1: `y_in` must settle within one cycle of the vector change.
- `rst` mid-run:
  - At that edge, all outputs return to reset values and state → IDLE.
  - No `done` pulse; partial `captured`/`fail_mask` discarded.
- `rst` and `start` on the same edge: reset wins, start dropped.

## Configuration

- `GATE_SEQ_HALT_ON_FAIL_EN` defined:
  - The first mismatch ends the run at its capture edge: → DONE, `done` pulses next cycle, `a_out`/`b_out` cleared.
  - `fail_mask` has only that vector's bit set; later `captured` bits remain 0; `pass`=0.
- Not defined: all four vectors always run and `fail_mask` may contain multiple bits.

## Test plan

- `and_gate` attached, S=10, start pulse at E0 → `a_out`/`b_out` = 00, 01, 10, 11, each held 10 cycles; `done` after E40; `captured`=4'b1000, `fail_mask`=0, `pass`=1.
- `y_in` tied 0, default EXPECT_TT → `captured`=4'b0000, `fail_mask`=4'b1000, `pass`=0.
- OR gate attached, default EXPECT_TT → `captured`=4'b1110, `fail_mask`=4'b0110, `pass`=0.
- `rst` asserted at E15 of a run → next cycle all outputs 0, no `done`. New start at E20 → full run, `done` after E60.
- Timing of start around a run:
  - `start` held high across a whole run → second start ignored until IDLE.
  - `start` high in the `done` cycle → ignored.
  - Start one cycle later → accepted, `busy`=1, results cleared.
- With `GATE_SEQ_HALT_ON_FAIL_EN`, OR gate, S=4 → mismatch on vector 1 captured at E8; `done` after E8; `fail_mask`=4'b0010, `captured`=4'b0010, `pass`=0.
